// File: rtl/fwrisc_fetch_pfq.sv
// Prefetching instruction fetch: buffers sequential words, assembles 16/32-bit
// instructions (including word-straddling ones) and redirects on non-sequential PC.
module fwrisc_fetch_pfq #(
    parameter bit          ENABLE_COMPRESSED = 1'b1,
    parameter int unsigned FIFO_DEPTH        = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        next_pc_seq,
    output logic [31:0] iaddr,
    input  logic [31:0] idata,
    output logic        ivalid,
    input  logic        iready,
    output logic        fetch_valid,
    input  logic        decode_complete,
    output logic [31:0] instr,
    output logic        instr_c,
    output logic [31:0] instr_pc
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned AvW  = PtrW + 2;

    typedef enum logic [1:0] {StStart, StRun, StDrain} state_e;

    state_e          state_q, state_d;
    logic [31:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d, head_nxt;
    logic [CntW-1:0] count_q, count_d;
    logic            hoff_q, hoff_d;
    logic [31:0]     pc_q, pc_d, faddr_q, faddr_d, iaddr_q, iaddr_d;
    logic            ivalid_q, ivalid_d;

    logic [31:0] w0;
    logic [15:0] w1_lo, hw0, hw1;
    logic        is_c;
    logic [1:0]  need, pos;
    logic        consume, redirect, ack, push, pop, load;

    // Head instruction view; hw1 may come from the following word when hoff is set.
    always_comb begin
        head_nxt = head_q + PtrW'(1);
        w0       = mem_q[head_q];
        w1_lo    = mem_q[head_nxt][15:0];
        hw0      = hoff_q ? w0[31:16] : w0[15:0];
        hw1      = hoff_q ? w1_lo : w0[31:16];
        is_c     = ENABLE_COMPRESSED && (hw0[1:0] != 2'b11);
        need     = is_c ? 2'd1 : 2'd2;
        fetch_valid = (state_q == StRun) &&
                      ({count_q, 1'b0} >= AvW'(need) + AvW'(hoff_q));
        instr    = 32'h0;
        instr_c  = 1'b0;
        if (fetch_valid) begin
            instr   = is_c ? {16'h0, hw0} : {hw1, hw0};
            instr_c = is_c;
        end
    end

    always_comb begin
        consume  = fetch_valid && decode_complete && next_pc_seq;
        redirect = fetch_valid && decode_complete && !next_pc_seq;
        ack      = ivalid_q && iready;
        push     = ack && (state_q == StRun) && !redirect;
        pos      = {1'b0, hoff_q} + need;
        pop      = consume && pos[1];
        load     = 1'b0;

        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        hoff_d  = hoff_q;
        pc_d    = pc_q;
        faddr_d = faddr_q;
        count_d = count_q + CntW'(push) - CntW'(pop);

        if (push) begin
            tail_d  = tail_q + PtrW'(1);
            faddr_d = faddr_q + 32'd4;
        end
        if (consume) begin
            head_d = head_q + PtrW'(pop);
            hoff_d = pos[0];
            pc_d   = pc_q + (is_c ? 32'd2 : 32'd4);
        end

        unique case (state_q)
            StStart: begin
                load    = 1'b1;
                state_d = StRun;
            end
            StRun: begin
                if (redirect) begin
                    load = 1'b1;
                    // The in-flight response still has to be absorbed before refetching.
                    if (ivalid_q && !iready) state_d = StDrain;
                end
            end
            StDrain: begin
                if (iready) state_d = StRun;
            end
            default: state_d = StStart;
        endcase

        if (load) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            faddr_d = {next_pc[31:2], 2'b00};
            hoff_d  = ENABLE_COMPRESSED && next_pc[1];
            pc_d    = {next_pc[31:2], ENABLE_COMPRESSED && next_pc[1], next_pc[0]};
        end

        if (ivalid_q) begin
            ivalid_d = !iready;
        end else begin
            ivalid_d = (state_d == StRun) && (count_d < CntW'(FIFO_DEPTH));
        end
        iaddr_d = (!ivalid_q && ivalid_d) ? faddr_d : iaddr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StStart;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            hoff_q   <= 1'b0;
            pc_q     <= '0;
            faddr_q  <= '0;
            iaddr_q  <= '0;
            ivalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            hoff_q   <= hoff_d;
            pc_q     <= pc_d;
            faddr_q  <= faddr_d;
            iaddr_q  <= iaddr_d;
            ivalid_q <= ivalid_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[tail_q] <= idata;
    end

    assign ivalid   = ivalid_q;
    assign iaddr    = iaddr_q;
    assign instr_pc = pc_q;

endmodule

// File: doc/fwrisc_fetch_pfq.md
Name: fwrisc_fetch_pfq

Overview:
Prefetching instruction-fetch unit with a parametrised word queue, replacing the single-shot fetcher. It keeps fetching sequential words into a FIFO_DEPTH-entry buffer while decode works. It assembles 16-bit (compressed) and 32-bit instructions, including 32-bit instructions that straddle a word boundary. It flushes and redirects on non-sequential PC. It sits between the instruction-memory port and the decode stage.

Parameters:
ENABLE_COMPRESSED, 1, 1 = RVC halfword handling; 0 = every instruction is 32-bit and next_pc[1] is ignored.
FIFO_DEPTH, 2, number of 32-bit words buffered; power of 2, at least 2.

Ports:
clock  input  1  clock
reset  input  1  reset, synchronous, active-high
next_pc  input  32  PC of the next instruction; sampled at start-up and on redirect
next_pc_seq  input  1  qualifies decode_complete: 1 = next instruction follows the current one; 0 = redirect to next_pc
iaddr  output  32  word-aligned fetch address (bits [1:0] always 0)
idata  input  32  fetch data, valid in the cycle ivalid && iready
ivalid  output  1  fetch request
iready  input  1  fetch complete; single-cycle pulse
fetch_valid  output  1  instr/instr_c/instr_pc valid
decode_complete  input  1  decode consumes the current instruction; legal only while fetch_valid=1
instr  output  32  instruction; compressed form is {16'h0, halfword}
instr_c  output  1  1 = instr is a 16-bit instruction
instr_pc  output  32  address of instr

Behaviour:
- Reset values: ivalid=0, iaddr=0, fetch_valid=0, instr=0, instr_c=0, instr_pc=0. Buffer empty, no request in flight, START state.
- States:
  - START: first cycle after reset; load faddr={next_pc[31:2],2'b0}, hoff=next_pc[1] (0 if !ENABLE_COMPRESSED), pc=next_pc; go to RUN.
  - RUN: normal operation.
  - DRAIN: a redirect occurred while a request was in flight; wait for that iready, drop its data, then go to RUN.
- Request rule:
  - In RUN, assert ivalid with iaddr=faddr when count < FIFO_DEPTH, counting an in-flight request.
  - ivalid and iaddr stay stable until iready.
  - On iready: push idata, faddr += 4, ivalid deasserts for at least one cycle.
- Availability: avail_hw = 2*count - hoff.
  - Head halfword hw0 = word[head] bits selected by hoff; hw1 = the next halfword, which may come from word[head+1].
  - need = 1 if ENABLE_COMPRESSED && hw0[1:0] != 2'b11, else 2.
  - fetch_valid = RUN && avail_hw >= need. This is combinational from registered buffer state; no same-cycle bypass from idata.
  - Latency: aligned 32-bit instruction from empty queue: fetch_valid is high the cycle after iready. Straddling instruction: the cycle after the second iready.
- Consume on decode_complete with next_pc_seq=1:
  - advance hoff/head by need halfwords; pop a word each time a word boundary is crossed;
  - pc += 2 or 4.
- Push and pop in the same cycle are both applied.
- Redirect on decode_complete with next_pc_seq=0:
  - flush buffer (count=0); load faddr, hoff and pc from next_pc;
  - fetch_valid=0 next cycle.
  - If a request is in flight and iready is not present this cycle, go to DRAIN.
  - If iready coincides with the redirect, drop the data and stay in RUN.
- Full: no request is issued; in-flight data always has space reserved.
- Wrap: head/tail pointers are log2(FIFO_DEPTH) bits and wrap modulo depth; faddr wraps at 2^32.
- Reset mid-request returns to the reset state immediately; a later iready for the abandoned request is ignored (ivalid=0).

Test Plan:
- Reset, next_pc=0x100, memory 32-bit NOPs 0x00000013, iready one cycle after each request -> iaddr 0x100, 0x104, ...; instr=0x00000013, instr_c=0, instr_pc 0x100, 0x104, ...; FIFO_DEPTH=2 stops requests when 2 words are held and decode stalls.
- Word 0x200 = {16'h4505 (c.li), 16'h0001 (c.nop)}, next_pc=0x200 -> instr=0x00000001 instr_c=1 pc 0x200, then instr=0x00004505 pc 0x202; exactly one pop.
- next_pc=0x302, words 0x300={16'h0093, 16'hxxxx}, 0x304={16'hxxxx, 16'h0000} -> 32-bit instr 0x00000093 assembled from both words, instr_pc=0x302, fetch_valid the cycle after the second iready.
- Redirect to 0x400 (next_pc_seq=0) while a request for 0x108 is in flight -> 0x108 data discarded, next iaddr=0x400, first instr_pc=0x400.
- Redirect in the same cycle as iready -> that data is dropped; no DRAIN cycle.
- ENABLE_COMPRESSED=0 with halfword 0x0001 at the head -> treated as 32-bit, instr_c=0; reset asserted mid-request -> ivalid=0 next cycle, all outputs at reset values.
